sos_sequencer: RTL and testbench
================================

Name: sos_sequencer

Overview:
- Control stage directly upstream of the S/O Morse pulse generator.
- On a trigger it drives that generator's one-hot func_start[1:0] through the word S-O-S and waits for each func_done pulse.
- Inserts timed silent gaps between letters and between repeated words.
- Reports busy and a one-cycle completion pulse to the top-level key/LED logic.

Parameters:
- T1MS, 16'd49_999, clock cycles per millisecond minus 1 (50 MHz clk).
- LETTER_GAP_MS, 10'd150, silent gap between letters in ms; 0 means no gap.
- WORD_GAP_MS, 10'd700, silent gap between repeated words in ms; 0 means no gap.
- REPEAT, 4'd1, number of S-O-S words per trigger; 0 is treated as 1.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- trig, input, 1, single-cycle start request from the debounced key.
- func_done, input, 1, one-cycle done pulse from the S/O generator.
- func_start, output, 2, registered one-hot letter select: 2'b10 = S, 2'b01 = O, 2'b00 = idle.
- busy, output, 1, high from the cycle after an accepted trig until the cycle seq_done is asserted.
- seq_done, output, 1, one-cycle pulse when the whole sequence completes.
- abort, input, 1, stop request; present only with SOS_ABORT_EN.

Behaviour:
- Reset: one clock, asynchronous active-low reset on rst_n. All outputs are low. State is IDLE. All counters are 0.
- States:
  - IDLE: trig=1 accepted, go to ISSUE, busy<=1. trig is ignored in every other state.
  - ISSUE: func_start <= (letter_idx==1) ? 2'b01 : 2'b10. Go to WAIT_DONE.
  - WAIT_DONE: func_start held stable. On func_done=1, clear func_start at the next edge, so the generator still sees start during its own clean-up cycle. Then:
    - letter_idx<2: letter_idx++, go to LGAP.
    - letter_idx==2 and rep_cnt<REPEAT-1: letter_idx<=0, rep_cnt++, go to WGAP.
    - otherwise: go to FINISH.
  - LGAP / WGAP: func_start=00. Stay exactly LETTER_GAP_MS (WGAP: WORD_GAP_MS) × (T1MS+1) cycles, then go to ISSUE. A zero gap goes to ISSUE on the next cycle.
  - FINISH: seq_done=1 for one cycle, busy<=0, counters cleared, go to IDLE.
- func_start is never changed while the generator is mid-letter. Dropping it freezes the generator.
- func_start is never 2'b11.
- Timebase: 16-bit ms_tick counter runs 0..T1MS only in gap states and clears on gap entry. A 10-bit ms counter compares for equality with the gap value.
- func_done seen outside WAIT_DONE is ignored.
- A func_done arriving in the same cycle func_start is first asserted is not possible; no special handling.
- Reset mid-operation returns to IDLE immediately with func_start=00. The generator is reset by the same rst_n.

Optional Feature:
- Macro: SOS_ABORT_EN.
- With the macro: abort input present. abort=1 in any busy state sets a sticky abort_req.
  - If a letter is in progress, it completes normally in WAIT_DONE, then the block goes to FINISH.
  - In LGAP/WGAP/ISSUE-pending-free states it goes to FINISH next cycle.
  - seq_done pulses as normal. abort_req clears in FINISH.
  - abort in IDLE is ignored.
- Without the macro: no abort port; sequence always runs to completion.

Test Plan:
- T1MS=9, gaps 3/7, REPEAT=1; responder pulses func_done 20 cycles after start -> func_start 10,01,10 in order. Each letter is separated by exactly 30 idle cycles after func_done. seq_done is a single pulse and busy then falls.
- REPEAT=2 -> six letters S,O,S,S,O,S. Exactly 70 idle cycles between the 3rd and 4th letters. One seq_done only.
- trig pulsed again while busy and in each gap -> ignored. Letter count remains 3. No extra seq_done.
- LETTER_GAP_MS=0, WORD_GAP_MS=0 -> next ISSUE 1 cycle after func_start clears. func_start is never 11.
- rst_n pulsed low during the O letter -> func_start=00, busy=0, seq_done=0 asynchronously. A new trig restarts from S.
- With SOS_ABORT_EN, abort during the O letter -> O completes, the final S is never issued, seq_done pulses once after the O func_done.

Source files
------------

// File: rtl/sos_sequencer.sv
// sos_sequencer: drives the S/O Morse pulse generator through S-O-S words.
// Each letter is issued on func_start and held until the generator's
// func_done pulse. Timed silent gaps go between letters and between
// repeated words. busy and a one-cycle seq_done go to the key/LED logic.
// Optional feature: define SOS_ABORT_EN to add the abort input. Abort lets
// the current letter finish and then ends the sequence early.
module sos_sequencer #(
   parameter logic [15:0] T1MS          = 16'd49_999,
   parameter logic [9:0]  LETTER_GAP_MS = 10'd150,
   parameter logic [9:0]  WORD_GAP_MS   = 10'd700,
   parameter logic [3:0]  REPEAT        = 4'd1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       trig,
   input  logic       func_done,
`ifdef SOS_ABORT_EN
   input  logic       abort,
`endif
   output logic [1:0] func_start,
   output logic       busy,
   output logic       seq_done
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_DONE,
      LGAP,
      WGAP,
      FINISH
   } state_t;

   // A REPEAT of zero still plays one word.
   localparam logic [3:0] REP_LAST = (REPEAT == 4'd0) ? 4'd0 : (REPEAT - 4'd1);

   state_t      state_q, state_d;
   logic [1:0]  func_start_q, func_start_d;
   logic        busy_q, busy_d;
   logic        seq_done_q, seq_done_d;
   logic [1:0]  letter_idx_q, letter_idx_d;
   logic [3:0]  rep_cnt_q, rep_cnt_d;
   logic [15:0] ms_tick_q, ms_tick_d;
   logic [9:0]  ms_cnt_q, ms_cnt_d;
   logic        abort_req_q, abort_req_d;

   logic        abort_in;
   logic        abort_hit;
   logic [9:0]  gap_len;
   logic        gap_last;

`ifdef SOS_ABORT_EN
   assign abort_in = abort;
`else
   assign abort_in = 1'b0;
`endif

   // An abort counts from the cycle it is seen, and also later through the sticky request.
   assign abort_hit = abort_req_q | (abort_in && (state_q != IDLE));

   // Gap length for the current gap state, plus detection of its final cycle.
   always_comb begin
      gap_len  = (state_q == WGAP) ? WORD_GAP_MS : LETTER_GAP_MS;
      gap_last = (gap_len == 10'd0) ||
                 ((ms_tick_q == T1MS) && (ms_cnt_q == (gap_len - 10'd1)));
   end

   // Next-state logic for the sequencer, its counters and its registered outputs.
   always_comb begin
      state_d      = state_q;
      func_start_d = func_start_q;
      busy_d       = busy_q;
      seq_done_d   = 1'b0;
      letter_idx_d = letter_idx_q;
      rep_cnt_d    = rep_cnt_q;
      ms_tick_d    = ms_tick_q;
      ms_cnt_d     = ms_cnt_q;
      abort_req_d  = abort_req_q;

      if (abort_in && (state_q != IDLE) && (state_q != FINISH)) begin
         abort_req_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (trig) begin
               state_d      = ISSUE;
               busy_d       = 1'b1;
               letter_idx_d = 2'd0;
               rep_cnt_d    = 4'd0;
            end
         end

         ISSUE: begin
            if (abort_hit) begin
               state_d = FINISH;
            end else begin
               func_start_d = (letter_idx_q == 2'd1) ? 2'b01 : 2'b10;
               state_d      = WAIT_DONE;
            end
         end

         WAIT_DONE: begin
            if (func_done) begin
               func_start_d = 2'b00;
               ms_tick_d    = 16'd0;
               ms_cnt_d     = 10'd0;
               if (abort_hit) begin
                  state_d = FINISH;
               end else if (letter_idx_q < 2'd2) begin
                  letter_idx_d = letter_idx_q + 2'd1;
                  state_d      = LGAP;
               end else if (rep_cnt_q < REP_LAST) begin
                  letter_idx_d = 2'd0;
                  rep_cnt_d    = rep_cnt_q + 4'd1;
                  state_d      = WGAP;
               end else begin
                  state_d = FINISH;
               end
            end
         end

         LGAP, WGAP: begin
            func_start_d = 2'b00;
            if (abort_hit) begin
               state_d = FINISH;
            end else if (gap_last) begin
               ms_tick_d = 16'd0;
               ms_cnt_d  = 10'd0;
               state_d   = ISSUE;
            end else if (ms_tick_q == T1MS) begin
               ms_tick_d = 16'd0;
               ms_cnt_d  = ms_cnt_q + 10'd1;
            end else begin
               ms_tick_d = ms_tick_q + 16'd1;
            end
         end

         FINISH: begin
            func_start_d = 2'b00;
            seq_done_d   = 1'b1;
            busy_d       = 1'b0;
            letter_idx_d = 2'd0;
            rep_cnt_d    = 4'd0;
            ms_tick_d    = 16'd0;
            ms_cnt_d     = 10'd0;
            abort_req_d  = 1'b0;
            state_d      = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers. Reset drops func_start at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         func_start_q <= 2'b00;
         busy_q       <= 1'b0;
         seq_done_q   <= 1'b0;
         letter_idx_q <= 2'd0;
         rep_cnt_q    <= 4'd0;
         ms_tick_q    <= 16'd0;
         ms_cnt_q     <= 10'd0;
         abort_req_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         func_start_q <= func_start_d;
         busy_q       <= busy_d;
         seq_done_q   <= seq_done_d;
         letter_idx_q <= letter_idx_d;
         rep_cnt_q    <= rep_cnt_d;
         ms_tick_q    <= ms_tick_d;
         ms_cnt_q     <= ms_cnt_d;
         abort_req_q  <= abort_req_d;
      end
   end

   assign func_start = func_start_q;
   assign busy       = busy_q;
   assign seq_done   = seq_done_q;

endmodule

// File: tb/tb_sos_sequencer.sv
// tb_sos_sequencer: three sequencer instances with a 10-cycle millisecond.
// Instance 0 uses gaps 3/7 ms and REPEAT=1. Instance 1 uses gaps 3/7 ms and
// REPEAT=2. Instance 2 uses gaps 0/0 and REPEAT=2. A responder stands in for
// the S/O generator. Define SOS_ABORT_EN to also exercise the abort input.
module tb_sos_sequencer;

   localparam logic [15:0] T1MS = 16'd9;
   localparam int NI = 3;

   typedef struct {
      int inst;
      int delay;
      bit spam;
      int exp_letters;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic       trig_a   [NI];
   logic       done_a   [NI];
   logic [1:0] fs       [NI];
   logic       busy_w   [NI];
   logic       sd_w     [NI];
`ifdef SOS_ABORT_EN
   logic       abort_a  [NI];
`endif

   int total = 0;
   int bad   = 0;
   int act   = 0;
   int resp_delay = 20;
   int cyc   = 0;

   logic [1:0] prev_fs;
   int         zero_run;
   bit         seen_letter;
   int         done_at;
   bit         done_last;
   int         bad11;
   int         unstable;
   int         busy_at_done;
   logic [1:0] letters   [$];
   int         gaps      [$];
   int         starts    [$];
   int         done_cycs [$];
   int         sd_cycs   [$];

   sos_sequencer #(.T1MS(T1MS), .LETTER_GAP_MS(10'd3), .WORD_GAP_MS(10'd7), .REPEAT(4'd1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .trig(trig_a[0]), .func_done(done_a[0]),
`ifdef SOS_ABORT_EN
      .abort(abort_a[0]),
`endif
      .func_start(fs[0]), .busy(busy_w[0]), .seq_done(sd_w[0]));

   sos_sequencer #(.T1MS(T1MS), .LETTER_GAP_MS(10'd3), .WORD_GAP_MS(10'd7), .REPEAT(4'd2)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .trig(trig_a[1]), .func_done(done_a[1]),
`ifdef SOS_ABORT_EN
      .abort(abort_a[1]),
`endif
      .func_start(fs[1]), .busy(busy_w[1]), .seq_done(sd_w[1]));

   sos_sequencer #(.T1MS(T1MS), .LETTER_GAP_MS(10'd0), .WORD_GAP_MS(10'd0), .REPEAT(4'd2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .trig(trig_a[2]), .func_done(done_a[2]),
`ifdef SOS_ABORT_EN
      .abort(abort_a[2]),
`endif
      .func_start(fs[2]), .busy(busy_w[2]), .seq_done(sd_w[2]));

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Backstop in case some wait escapes its cycle budget.
   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model: configuration of each instance.
   function automatic int lgap_of(input int i);
      return (i == 2) ? 0 : 3;
   endfunction

   function automatic int wgap_of(input int i);
      return (i == 2) ? 0 : 7;
   endfunction

   function automatic int reps_of(input int i);
      return (i == 0) ? 1 : 2;
   endfunction

   // Cycles of func_start=00 between two letters: the silent interval is at
   // least one cycle, and one ISSUE cycle follows it.
   function automatic int gap_cycles(input int ms);
      int c;
      c = ms * (int'(T1MS) + 1);
      if (c < 1) c = 1;
      return c + 1;
   endfunction

   // Letter n of the word S-O-S repeated.
   function automatic logic [1:0] exp_letter(input int n);
      return ((n % 3) == 1) ? 2'b01 : 2'b10;
   endfunction

   task automatic checkOutput(input string name, input int got, input int expv);
      total++;
      if (got != expv) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, got, expv);
      end
   endtask

   task automatic clearLogs();
      prev_fs = 2'b00;
      zero_run = 0;
      seen_letter = 1'b0;
      done_at = -1;
      done_last = 1'b0;
      bad11 = 0;
      unstable = 0;
      busy_at_done = 0;
      letters.delete();
      gaps.delete();
      starts.delete();
      done_cycs.delete();
      sd_cycs.delete();
      for (int i = 0; i < NI; i++) begin
         trig_a[i] = 1'b0;
         done_a[i] = 1'b0;
      end
   endtask

   // One clock: sample the active instance at the falling edge, log events,
   // then drive trig and the generator's func_done for the next rising edge.
   task automatic stepCycle(input bit t, input bit spam);
      logic [1:0] fs_now;
      bit         d_now;
      @(negedge clk);
      cyc++;
      fs_now = fs[act];
      if (fs_now == 2'b11) bad11++;
      if (done_last) begin
         if (fs_now != 2'b00) unstable++;
      end else if ((prev_fs != 2'b00) && (fs_now != prev_fs)) begin
         unstable++;
      end
      if ((prev_fs == 2'b00) && (fs_now != 2'b00)) begin
         letters.push_back(fs_now);
         starts.push_back(cyc);
         if (seen_letter) gaps.push_back(zero_run);
         seen_letter = 1'b1;
         done_at = cyc + resp_delay - 1;
      end
      if (fs_now == 2'b00) zero_run++;
      else zero_run = 0;
      if (sd_w[act]) begin
         sd_cycs.push_back(cyc);
         if (busy_w[act]) busy_at_done++;
      end
      d_now = (fs_now != 2'b00) && (cyc == done_at);
      done_a[act] = d_now;
      if (d_now) done_cycs.push_back(cyc);
      done_last = d_now;
      trig_a[act] = t | (spam && busy_w[act] &&
                         ((fs_now == 2'b00) || ($urandom_range(0, 3) == 0)));
      prev_fs = fs_now;
   endtask

   // Step until seq_done has been seen and 40 quiet cycles have followed, or the budget runs out.
   task automatic runToDone(input bit spam, input int budget);
      int post;
      post = -1;
      for (int k = 0; k < budget; k++) begin
         stepCycle(1'b0, spam);
         if ((sd_cycs.size() > 0) && (post < 0)) post = 0;
         if (post >= 0) begin
            post++;
            if (post > 40) break;
         end
      end
      trig_a[act] = 1'b0;
   endtask

   // Run one triggered sequence on an instance and compare it against the model.
   task automatic applyStimulus(input int inst, input int delay, input bit spam, input int nl);
      int trig_cyc;
      act = inst;
      resp_delay = delay;
      clearLogs();
      stepCycle(1'b1, 1'b0);
      trig_cyc = cyc;
      stepCycle(1'b0, spam);
      checkOutput("busy_rise", int'(busy_w[act]), 1);
      runToDone(spam, 4000);

      checkOutput("letter_count", letters.size(), nl);
      for (int j = 0; j < letters.size() && j < nl; j++)
         checkOutput($sformatf("letter%0d", j), int'(letters[j]), int'(exp_letter(j)));
      checkOutput("gap_count", gaps.size(), nl - 1);
      for (int j = 0; j < gaps.size() && j < nl - 1; j++)
         checkOutput($sformatf("gap%0d", j), gaps[j],
                     ((j % 3) == 2) ? gap_cycles(wgap_of(inst)) : gap_cycles(lgap_of(inst)));
      checkOutput("first_start_latency", (starts.size() > 0) ? (starts[0] - trig_cyc) : -1, 2);
      checkOutput("seq_done_count", sd_cycs.size(), 1);
      checkOutput("seq_done_latency",
                  ((sd_cycs.size() > 0) && (done_cycs.size() > 0)) ?
                     (sd_cycs[0] - done_cycs[done_cycs.size() - 1]) : -1, 2);
      checkOutput("busy_at_seq_done", busy_at_done, 0);
      checkOutput("func_start_11", bad11, 0);
      checkOutput("func_start_stable", unstable, 0);
   endtask

   task automatic checkReset(input string tag);
      for (int i = 0; i < NI; i++) begin
         checkOutput($sformatf("%s_func_start%0d", tag, i), int'(fs[i]), 0);
         checkOutput($sformatf("%s_busy%0d", tag, i), int'(busy_w[i]), 0);
         checkOutput($sformatf("%s_seq_done%0d", tag, i), int'(sd_w[i]), 0);
      end
   endtask

   // Step until the O letter is on func_start (at most budget cycles).
   task automatic waitForO(input int budget);
      for (int k = 0; k < budget; k++) begin
         if (letters.size() >= 2) break;
         stepCycle(1'b0, 1'b0);
      end
   endtask

   vec_t vecs[8];

   initial begin
      rst_n = 1'b1;
      for (int i = 0; i < NI; i++) begin
         trig_a[i] = 1'b0;
         done_a[i] = 1'b0;
`ifdef SOS_ABORT_EN
         abort_a[i] = 1'b0;
`endif
      end
      #1 rst_n = 1'b0;
      #11;
      checkReset("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors first, then randomized ones.
      vecs[0] = '{0, 20, 1'b0, 3};
      vecs[1] = '{1, 20, 1'b0, 6};
      vecs[2] = '{0, 20, 1'b1, 3};
      vecs[3] = '{2, 20, 1'b1, 6};
      for (int i = 4; i < 8; i++) begin
         vecs[i].inst        = int'($urandom_range(0, 2));
         vecs[i].delay       = int'($urandom_range(2, 25));
         vecs[i].spam        = bit'($urandom_range(0, 1));
         vecs[i].exp_letters = 3 * reps_of(vecs[i].inst);
      end
      for (int i = 0; i < 8; i++) begin
         $display("[TB] vector %0d: inst=%0d delay=%0d spam=%0d", i,
                  vecs[i].inst, vecs[i].delay, vecs[i].spam);
         applyStimulus(vecs[i].inst, vecs[i].delay, vecs[i].spam, vecs[i].exp_letters);
      end

      // Reset in the middle of the O letter, then a clean restart from S.
      act = 0;
      resp_delay = 20;
      clearLogs();
      stepCycle(1'b1, 1'b0);
      waitForO(500);
      for (int k = 0; k < 3; k++) stepCycle(1'b0, 1'b0);
      checkOutput("pre_reset_letter", int'(fs[0]), 1);
      #2 rst_n = 1'b0;
      #1;
      checkReset("midreset");
      #1 rst_n = 1'b1;
      applyStimulus(0, 20, 1'b0, 3);

`ifdef SOS_ABORT_EN
      // Abort while O is playing: O finishes, the last S is never issued.
      act = 0;
      resp_delay = 20;
      clearLogs();
      stepCycle(1'b1, 1'b0);
      waitForO(500);
      for (int k = 0; k < 3; k++) stepCycle(1'b0, 1'b0);
      abort_a[0] = 1'b1;
      stepCycle(1'b0, 1'b0);
      abort_a[0] = 1'b0;
      runToDone(1'b0, 1000);
      checkOutput("abort_letter_count", letters.size(), 2);
      checkOutput("abort_last_letter", (letters.size() > 1) ? int'(letters[1]) : -1, 1);
      checkOutput("abort_seq_done_count", sd_cycs.size(), 1);
      checkOutput("abort_seq_done_latency",
                  ((sd_cycs.size() > 0) && (done_cycs.size() > 0)) ?
                     (sd_cycs[0] - done_cycs[done_cycs.size() - 1]) : -1, 2);
      checkOutput("abort_busy_at_seq_done", busy_at_done, 0);
      applyStimulus(0, 20, 1'b0, 3);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
